// File: rtl/rng_arbiter_if.sv
// Request/grant bus between NUM_REQ requesters, the RNG arbiter and the
// shared floatRNG. The arbiter uses the slave modport; the requester/RNG
// side uses the master modport.
interface rng_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] ack;
  logic [15:0]        data_out;
  logic               busy;
  logic               rng_call;
  logic [15:0]        rng_data;

  modport slave (
    input  req, rng_data,
    output grant, ack, data_out, busy, rng_call
  );

  modport master (
    output req, rng_data,
    input  grant, ack, data_out, busy, rng_call
  );
endinterface

// File: rtl/rng_arbiter.sv
// Shares one floatRNG among NUM_REQ requesters.
// Each transaction is IDLE -> CALL -> WAIT (RNG_LATENCY cycles) -> DONE.
// In DONE, ack pulses to the owner and data_out holds the sampled value.
// Build option: define RNG_ARB_FIXED_PRIO_EN to select fixed priority
// (lowest index wins). The default build uses round-robin arbitration,
// starting from last_granted+1.
module rng_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int RNG_LATENCY = 2
) (
  input logic          clock,
  input logic          reset,
  rng_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] CNT_LAST = 4'(RNG_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, CALL, WAIT, DONE} state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [15:0]        data_q;
  logic               busy_q;
  logic               call_q;
  logic [3:0]         cnt_q;

  logic [NUM_REQ-1:0] win_d;
  logic               found;

`ifdef RNG_ARB_FIXED_PRIO_EN
  // Fixed priority: the lowest-index active request wins.
  always_comb begin
    win_d = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req[k]) begin
        found    = 1'b1;
        win_d[k] = 1'b1;
      end
    end
  end
`else
  logic [IW-1:0] last_q;
  logic [IW-1:0] win_idx_d;
  logic [IW-1:0] idx;

  // Round-robin: search starts at the requester after the last owner.
  always_comb begin
    win_d     = '0;
    win_idx_d = last_q;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IW'((int'(last_q) + 1 + k) % NUM_REQ);
      if (!found && bus.req[idx]) begin
        found      = 1'b1;
        win_d[idx] = 1'b1;
        win_idx_d  = idx;
      end
    end
  end
`endif

  // Transaction FSM. All outputs are registered here, and rng_data is
  // read only on the last WAIT edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      data_q  <= 16'h0000;
      busy_q  <= 1'b0;
      call_q  <= 1'b0;
      cnt_q   <= 4'd0;
`ifndef RNG_ARB_FIXED_PRIO_EN
      last_q  <= IW'(NUM_REQ - 1);
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            grant_q <= win_d;
            call_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= CALL;
`ifndef RNG_ARB_FIXED_PRIO_EN
            last_q  <= win_idx_d;
`endif
          end
        end
        CALL: begin
          call_q  <= 1'b0;
          cnt_q   <= 4'd0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == CNT_LAST) begin
            data_q  <= bus.rng_data;
            ack_q   <= grant_q;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          ack_q   <= '0;
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.ack      = ack_q;
  assign bus.data_out = data_q;
  assign bus.busy     = busy_q;
  assign bus.rng_call = call_q;
endmodule

// File: tb/tb_rng_arbiter.sv
// Bench for rng_arbiter. Three instances are used: the default latency
// (2), plus latency 1 and latency 5 for the latency sweep. The RNG
// model returns a value that depends on the cycle, so any change in
// the sample time shows up in data_out.
module tb_rng_arbiter;
  logic clock;
  logic reset;
  logic ovr;
  int   cyc;
  int   checks;
  int   errors;

  rng_arbiter_if #(.NUM_REQ(4)) bus0 ();
  rng_arbiter_if #(.NUM_REQ(4)) bus1 ();
  rng_arbiter_if #(.NUM_REQ(4)) bus5 ();

  rng_arbiter #(.NUM_REQ(4), .RNG_LATENCY(2)) dut (.clock(clock), .reset(reset), .bus(bus0));
  rng_arbiter #(.NUM_REQ(4), .RNG_LATENCY(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
  rng_arbiter #(.NUM_REQ(4), .RNG_LATENCY(5)) dut5 (.clock(clock), .reset(reset), .bus(bus5));

  function automatic logic [15:0] rng_fn(input int c);
    logic [7:0] b;
    b = 8'(c);
    return {b ^ 8'h5A, b};
  endfunction

  assign bus0.rng_data = ovr ? 16'h3C00 : rng_fn(cyc);
  assign bus1.rng_data = rng_fn(cyc);
  assign bus5.rng_data = rng_fn(cyc);

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          dut;
    int          cyc;
    logic [3:0]  ack;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int d, input int c, input logic [3:0] a, input logic [15:0] v);
    exp_t e;
    e.dut = d; e.cyc = c; e.ack = a; e.data = v;
    sb.push_back(e);
  endtask

  task automatic at_cycle(input int n);
    while (cyc != n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_grant"}, 32'(bus0.grant), 0);
    chk({nm, "_ack"}, 32'(bus0.ack), 0);
    chk({nm, "_call"}, 32'(bus0.rng_call), 0);
    chk({nm, "_busy"}, 32'(bus0.busy), 0);
    chk({nm, "_data"}, 32'(bus0.data_out), 0);
  endtask

  function automatic logic [3:0] exp_rr(input int k);
`ifdef RNG_ARB_FIXED_PRIO_EN
    return 4'b0001;
`else
    logic [3:0] one;
    one = 4'b0001;
    return one << (k % 4);
`endif
  endfunction

  // Monitor: every ack from any instance must match the oldest
  // expectation queued for that instance.
  logic [2:0][3:0]  ackv;
  logic [2:0][15:0] datv;
  assign ackv[0] = bus0.ack;
  assign ackv[1] = bus1.ack;
  assign ackv[2] = bus5.ack;
  assign datv[0] = bus0.data_out;
  assign datv[1] = bus1.data_out;
  assign datv[2] = bus5.data_out;

  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (ackv[i] != 4'b0000) begin
        int fi;
        fi = -1;
        for (int j = 0; j < sb.size(); j++)
          if (fi < 0 && sb[j].dut == i) fi = j;
        if (fi < 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack dut%0d got %b want none (cycle %0d)", i, ackv[i], cyc);
        end else begin
          chk($sformatf("ack_cycle_dut%0d", i), 32'(cyc), 32'(sb[fi].cyc));
          chk($sformatf("ack_vec_dut%0d", i), 32'(ackv[i]), 32'(sb[fi].ack));
          chk($sformatf("data_dut%0d", i), 32'(datv[i]), 32'(sb[fi].data));
          sb.delete(fi);
        end
      end
    end
  end

  logic [3:0] t1_grant [6] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
  logic       t1_call  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       t1_busy  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    ovr = 1'b0;
    reset = 1'b1;
    bus0.req = '0;
    bus1.req = '0;
    bus5.req = '0;

    // Reset state
    at_cycle(1);
    @(negedge clock);
    chk_zero("reset");
    at_cycle(2);
    reset = 1'b0;

    // Single request at cycle 10, plus the latency sweep on dut1/dut5
    for (int c = 10; c <= 15; c++) begin
      at_cycle(c);
      if (c == 10) begin
        bus0.req = 4'b0100;
        bus1.req = 4'b0100;
        bus5.req = 4'b0100;
        ovr = 1'b1;
        push(0, 14, 4'b0100, 16'h3C00);
        push(1, 13, 4'b0100, rng_fn(12));
        push(2, 17, 4'b0100, rng_fn(16));
      end
      if (c == 12) begin
        bus0.req = '0;
        bus1.req = '0;
        bus5.req = '0;
      end
      @(negedge clock);
      chk($sformatf("t1_grant_c%0d", c), 32'(bus0.grant), 32'(t1_grant[c-10]));
      chk($sformatf("t1_call_c%0d", c), 32'(bus0.rng_call), 32'(t1_call[c-10]));
      chk($sformatf("t1_busy_c%0d", c), 32'(bus0.busy), 32'(t1_busy[c-10]));
    end
    at_cycle(16);
    ovr = 1'b0;

    // Reset pulse while idle clears data_out and restarts the round-robin
    at_cycle(20);
    reset = 1'b1;
    #1;
    chk_zero("rst_idle");
    at_cycle(21);
    reset = 1'b0;

    // All requesters held high: one grant every 5 cycles
    at_cycle(22);
    bus0.req = 4'b1111;
    for (int k = 0; k < 5; k++) push(0, 26 + 5*k, exp_rr(k), rng_fn(25 + 5*k));
    at_cycle(44);
    bus0.req = '0;

    // Requester 1 withdraws during WAIT; requester 3 is served next
    at_cycle(50);
    bus0.req = 4'b0010;
    push(0, 54, 4'b0010, rng_fn(53));
    push(0, 59, 4'b1000, rng_fn(58));
    at_cycle(52);
    bus0.req = 4'b1000;
    at_cycle(56);
    bus0.req = '0;

    // Reset during WAIT discards the transaction
    at_cycle(65);
    bus0.req = 4'b0001;
    at_cycle(67);
    reset = 1'b1;
    #1;
    chk_zero("rst_wait");
    at_cycle(68);
    bus0.req = '0;
    at_cycle(69);
    reset = 1'b0;
    at_cycle(70);
    bus0.req = 4'b0001;
    push(0, 74, 4'b0001, rng_fn(73));
    at_cycle(71);
    bus0.req = '0;

    at_cycle(85);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rng_arbiter.md
RNG_ARBITER -- requirements
Module: rng_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter RNG_LATENCY, default 2: cycles from the floatRNG call cycle to valid rng_data (1..15).
REQ-003 SHALL have port clock  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester random-number request, level, held until ack.
REQ-006 SHALL have port grant  output  NUM_REQ  one-hot owner of the RNG; zero when idle.
REQ-007 SHALL have port ack  output  NUM_REQ  one-cycle pulse to the granted requester when data_out is valid.
REQ-008 SHALL have port data_out  output  16  float16 random value, valid in the ack cycle, held until the next ack.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port rng_call  output  1  drives the call input of the shared floatRNG.
REQ-011 SHALL have port rng_data  input  16  the data output of the shared floatRNG.

Function
REQ-012 SHALL implement the FSM states IDLE, CALL, WAIT and DONE.
REQ-013 IDLE SHALL move to CALL on the edge where any req bit is high, registering the winner into grant; otherwise it SHALL stay in IDLE.
REQ-014 CALL SHALL assert rng_call for exactly one cycle, then move to WAIT.
REQ-015 WAIT SHALL count RNG_LATENCY-1 cycles, then sample rng_data into data_out on the edge ending the cycle RNG_LATENCY after CALL, and move to DONE.
REQ-016 DONE SHALL pulse ack for the grant bit for one cycle, then move to IDLE and clear grant.
REQ-017 Latency SHALL be: req first high in IDLE cycle t -> ack in cycle t+RNG_LATENCY+2 (t+4 at default).
REQ-018 Throughput SHALL be one result per RNG_LATENCY+3 cycles under continuous requests.
REQ-019 Arbitration (macro absent) SHALL be round-robin: the search starts at last_granted+1 modulo NUM_REQ.
REQ-020 last_granted SHALL update only on entry to CALL.
REQ-021 A grant SHALL NOT be revoked if its req drops mid-transaction; ack still pulses and data_out still updates.
REQ-022 A req that is still high in the cycle after its ack SHALL count as a new request and compete normally.
REQ-023 req changes outside IDLE SHALL be ignored until the next IDLE evaluation.
REQ-024 rng_call SHALL be low in all states except CALL.
REQ-025 The block SHALL NOT inspect rng_data outside the sample edge.

Reset
REQ-026 Asserting reset SHALL immediately force IDLE, grant=0, ack=0, rng_call=0, busy=0, data_out=16'h0000, the WAIT counter to 0 and last_granted to NUM_REQ-1, so req[0] wins first.
REQ-027 Reset mid-transaction SHALL discard the in-flight result; no ack SHALL follow reset release until a new full transaction completes.
REQ-028 The first IDLE evaluation SHALL occur on the first clock edge after reset deasserts.

Configuration
REQ-029 The macro RNG_ARB_FIXED_PRIO_EN SHALL select the arbitration scheme.
REQ-030 With RNG_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (lowest index wins), and last_granted and its logic SHALL be omitted.
REQ-031 Without RNG_ARB_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-019.

Verification
REQ-032 Single request: with req=4'b0100 at cycle 10 and rng_data=16'h3C00 in the sample cycle -> grant=4'b0100 at cycle 11, rng_call high only at cycle 11, ack=4'b0100 and data_out=16'h3C00 at cycle 14.
REQ-033 Round-robin fairness: with req=4'b1111 held high -> grants follow the order 0,1,2,3,0, one every 5 cycles; with RNG_ARB_FIXED_PRIO_EN -> grant is always 4'b0001.
REQ-034 Request withdrawal: req[1] drops in the WAIT state -> ack[1] still pulses; data_out updates; the next grant goes to any other pending requester.
REQ-035 Reset mid-operation: reset asserted in WAIT -> all outputs are zero within the same cycle; no ack for that transaction; after release, req=4'b0001 completes normally.
REQ-036 Latency sweep: RNG_LATENCY=1 and RNG_LATENCY=5 -> ack arrives at t+3 and t+7 respectively, and data_out equals rng_data sampled exactly RNG_LATENCY cycles after rng_call.
